// File: rtl/arith_trunci_buf.sv
// Registered integer truncation stage with overflow flagging.
// A 2-entry skid buffer decouples both the valid/data path and the ready path.
module arith_trunci_buf #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 16,
    parameter bit          SIGNED    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [IN_WIDTH-1:0]  a_data,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [OUT_WIDTH-1:0] result_data,
    output logic                 result_ovf,
    output logic                 ovf_sticky,
    input  logic                 ovf_clear
);

    if (OUT_WIDTH < 1 || IN_WIDTH <= OUT_WIDTH) begin : g_param_check
        $error("arith_trunci_buf: need IN_WIDTH > OUT_WIDTH >= 1");
    end

    logic in_ovf;

    if (SIGNED) begin : g_signed
        // Value survives only if the dropped bits all replicate the new sign bit.
        logic [IN_WIDTH-OUT_WIDTH:0] top;
        assign top    = a_data[IN_WIDTH-1:OUT_WIDTH-1];
        assign in_ovf = !((&top) || !(|top));
    end else begin : g_unsigned
        assign in_ovf = |a_data[IN_WIDTH-1:OUT_WIDTH];
    end

    logic                 m_valid_q, m_valid_d;
    logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
    logic                 m_ovf_q, m_ovf_d;
    logic                 s_valid_q, s_valid_d;
    logic [OUT_WIDTH-1:0] s_data_q, s_data_d;
    logic                 s_ovf_q, s_ovf_d;
    logic                 a_ready_q, a_ready_d;
    logic                 sticky_q, sticky_d;
    logic                 in_xfer, out_xfer;

    assign in_xfer  = a_valid && a_ready_q;
    assign out_xfer = m_valid_q && result_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ovf_d   = m_ovf_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_ovf_d   = s_ovf_q;
        sticky_d  = sticky_q;

        if (!m_valid_q) begin
            if (in_xfer) begin
                m_valid_d = 1'b1;
                m_data_d  = a_data[OUT_WIDTH-1:0];
                m_ovf_d   = in_ovf;
            end
        end else if (!s_valid_q) begin
            if (in_xfer && out_xfer) begin
                m_data_d = a_data[OUT_WIDTH-1:0];
                m_ovf_d  = in_ovf;
            end else if (in_xfer) begin
                s_valid_d = 1'b1;
                s_data_d  = a_data[OUT_WIDTH-1:0];
                s_ovf_d   = in_ovf;
            end else if (out_xfer) begin
                m_valid_d = 1'b0;
            end
        end else if (out_xfer) begin
            m_data_d  = s_data_q;
            m_ovf_d   = s_ovf_q;
            s_valid_d = 1'b0;
        end

        a_ready_d = !s_valid_d;

        // A set from a departing overflow token takes priority over clear.
        if (out_xfer && m_ovf_q) begin
            sticky_d = 1'b1;
        end else if (ovf_clear) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ovf_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_ovf_q   <= 1'b0;
            a_ready_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ovf_q   <= m_ovf_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_ovf_q   <= s_ovf_d;
            a_ready_q <= a_ready_d;
            sticky_q  <= sticky_d;
        end
    end

    assign a_ready      = a_ready_q;
    assign result_valid = m_valid_q;
    assign result_data  = m_data_q;
    assign result_ovf   = m_ovf_q;
    assign ovf_sticky   = sticky_q;

endmodule

// File: doc/arith_trunci_buf.md
Name: arith_trunci_buf

Overview:
Registered integer truncation stage. It narrows a_data from IN_WIDTH to OUT_WIDTH bits, keeping the low bits. It flags tokens whose value does not survive the truncation, i.e. the inverse check of sign/zero extension. It sits between dataflow operators on valid/ready handshakes, breaking both the data/valid path and the ready path with a full-throughput 2-entry skid buffer.

Parameters:
IN_WIDTH, 32, input operand width; must be > OUT_WIDTH (elaboration error otherwise)
OUT_WIDTH, 16, result width; must be >= 1
SIGNED, 1, overflow rule: 1 = two's-complement check, 0 = unsigned check

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  input token valid
a_ready  output  1  stage can accept an input token
a_data  input  IN_WIDTH  input operand
result_valid  output  1  output token valid
result_ready  input  1  downstream accepts the output token
result_data  output  OUT_WIDTH  a_data[OUT_WIDTH-1:0] of the head token
result_ovf  output  1  head token lost information in truncation
ovf_sticky  output  1  an overflowed token has left the stage since the last clear
ovf_clear  input  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (rst_n low, asynchronous): main and skid entries are invalid.
  - result_valid=0, result_data=0, result_ovf=0, ovf_sticky=0, a_ready=0.
  - a_ready is a flop; it rises on the first clk edge after rst_n deasserts.
  - Reset mid-operation drops all held tokens.
- Overflow per token, computed at acceptance and stored with the data:
  - SIGNED=1: ovf = NOT(all of a_data[IN_WIDTH-1:OUT_WIDTH-1] equal).
  - SIGNED=0: ovf = |a_data[IN_WIDTH-1:OUT_WIDTH].
- Input transfer happens on a_valid && a_ready at the clk edge. Output transfer happens on result_valid && result_ready.
- Storage: main register M drives the outputs. Skid register S holds one overflow token.
- a_ready (registered) = NOT S.valid for the next cycle.
- Latency: 1 cycle from input transfer to result_valid when M is empty.
- Throughput: 1 token/cycle while result_ready stays high.
- Transitions per edge, with in = input transfer and out = output transfer:
  - EMPTY (M invalid): in -> M loaded.
  - ONE (M valid, S invalid):
    - in and out -> M reloaded.
    - in, no out -> S loaded; a_ready drops.
    - out, no in -> EMPTY.
  - FULL (M and S valid, a_ready=0):
    - out -> M <= S, S invalid; a_ready rises next cycle.
    - No input can be accepted in FULL.
- Ordering is strict FIFO. No token is dropped or duplicated under any a_valid/result_ready pattern.
- result_data, result_ovf and result_valid hold stable while result_valid=1 and result_ready=0.
- ovf_sticky:
  - Set on an output transfer with result_ovf=1.
  - Cleared on a clk edge with ovf_clear=1.
  - Set and clear in the same cycle: set wins.
- a_data is ignored when a_valid=0. result_data holds the last value when result_valid=0.

Test Plan:
1. Reset release, IN=32/OUT=16/SIGNED=1; drive 0x0000_1234 with result_ready=1 -> a_ready=1 one cycle after release; result_valid next cycle, result_data=0x1234, result_ovf=0, ovf_sticky=0.
2. Signed boundaries: 0xFFFF_8000, 0x0000_7FFF, 0x0000_8000, 0xFFFF_7FFF -> data 0x8000, 0x7FFF, 0x8000, 0x7FFF; ovf 0, 0, 1, 1; ovf_sticky=1 after the third output transfer.
3. SIGNED=0: 0x0000_FFFF -> 0xFFFF, ovf=0; 0x0001_0000 -> 0x0000, ovf=1.
4. Backpressure: stream 1,2,3,4 with result_ready=0 -> tokens 1 and 2 accepted, then a_ready=0 while result_data stays 1. Raise result_ready -> outputs 1,2,3,4 in order, one per cycle, none lost.
5. ovf_clear asserted in the same cycle an ovf token transfers -> ovf_sticky=1. ovf_clear alone next cycle -> ovf_sticky=0.
6. rst_n pulsed low asynchronously in the FULL state -> result_valid, a_ready and ovf_sticky drop to 0 immediately without a clk edge. No stale token appears after release.
